// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: OAM DMA block-copy sequencer plus CPU/DMA arbiter for the shared bus.
// A CPU write to REG_ADDR starts a LEN-byte copy from {src_hi,8'h00} into OAM.
// Each byte takes a READ cycle (DMA owns the bus) and a WRITE cycle (OAM strobe).
// While a copy runs the CPU only reaches HRAM, and never during a DMA READ cycle.
// Optional feature macro: OAM_DMA_RESTART_EN -- a register write during a running
// copy reloads the source page and restarts the copy from index 0.
module oam_dma_arbiter #(
    parameter int          LEN         = 160,
    parameter int          START_DELAY = 1,
    parameter logic [15:0] REG_ADDR    = 16'hFF46,
    parameter logic [15:0] HRAM_LO     = 16'hFF80,
    parameter logic [15:0] HRAM_HI     = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_wdata_i,
    input  logic        cpu_rd_i,
    input  logic        cpu_wr_i,
    output logic [7:0]  cpu_rdata_o,
    output logic        cpu_grant_o,
    output logic [15:0] bus_addr_o,
    output logic [7:0]  bus_wdata_o,
    output logic        bus_rd_o,
    output logic        bus_wr_o,
    input  logic [7:0]  bus_rdata_i,
    output logic [7:0]  oam_addr_o,
    output logic [7:0]  oam_wdata_o,
    output logic        oam_wr_o,
    output logic        dma_active_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } state_t;

    // One request on the shared bus, from whichever master owns it this cycle.
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        rd;
        logic        wr;
    } bus_req_t;

    // idx is 8 bits wide; LEN=256 makes IDX_LAST 8'hFF so idx wraps to 0 on completion.
    localparam logic [7:0] IDX_LAST = 8'(LEN - 1);
    localparam logic [3:0] DLY_LAST = 4'((START_DELAY > 0) ? START_DELAY - 1 : 0);
    localparam state_t     START_ST = (START_DELAY == 0) ? READ : DELAY;

    state_t     state_q, state_d;
    logic [7:0] idx_q,   idx_d;
    logic [7:0] src_q,   src_d;
    logic [3:0] dly_q,   dly_d;

    logic     is_reg;
    logic     reg_wr;
    logic     in_hram;
    logic     dma_active;
    logic     grant;
    bus_req_t bus;

    assign is_reg     = (cpu_addr_i == REG_ADDR);
    assign reg_wr     = cpu_wr_i && is_reg;
    assign in_hram    = (cpu_addr_i >= HRAM_LO) && (cpu_addr_i <= HRAM_HI);
    assign dma_active = (state_q != IDLE);

    // CPU is locked out of everything but HRAM while a copy runs, and out of HRAM
    // too during a DMA READ; nothing is granted while reset is held.
    assign grant = !rst && (!dma_active || (in_hram && (state_q != READ)));

    // Sequencer state registers; reset abandons any copy in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 8'h00;
            src_q   <= 8'h00;
            dly_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            src_q   <= src_d;
            dly_q   <= dly_d;
        end
    end

    // Next-state logic: register write starts a copy, then READ/WRITE pairs per byte.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        src_d   = src_q;
        dly_d   = dly_q;
        case (state_q)
            IDLE: begin
                if (reg_wr) begin
                    src_d   = cpu_wdata_i;
                    idx_d   = 8'h00;
                    dly_d   = 4'h0;
                    state_d = START_ST;
                end
            end
            DELAY: begin
                dly_d = dly_q + 4'h1;
                if (dly_q == DLY_LAST) begin
                    state_d = READ;
                end
            end
            READ: begin
                state_d = WRITE;
            end
            WRITE: begin
                idx_d = idx_q + 8'h01;
                if (idx_q == IDX_LAST) begin
                    idx_d   = 8'h00;
                    state_d = IDLE;
                end else begin
                    state_d = READ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef OAM_DMA_RESTART_EN
        // A register write mid-copy wins over the normal sequence; the WRITE strobe
        // driven this cycle is combinational from state_q, so that byte still lands.
        if (reg_wr && dma_active) begin
            src_d   = cpu_wdata_i;
            idx_d   = 8'h00;
            dly_d   = 4'h0;
            state_d = START_ST;
        end
`endif
    end

    // Bus mux, OAM strobe and CPU read data; everything forced to zero during reset.
    always_comb begin
        bus         = '0;
        oam_addr_o  = 8'h00;
        oam_wdata_o = 8'h00;
        oam_wr_o    = 1'b0;
        cpu_rdata_o = 8'h00;
        if (!rst) begin
            if (state_q == READ) begin
                bus.addr = {src_q, idx_q};
                bus.rd   = 1'b1;
            end else if (grant) begin
                // The DMA register is decoded here, so its accesses never go out.
                bus.addr  = cpu_addr_i;
                bus.wdata = cpu_wdata_i;
                bus.rd    = cpu_rd_i && !is_reg;
                bus.wr    = cpu_wr_i && !is_reg;
            end
            if (state_q == WRITE) begin
                oam_addr_o  = idx_q;
                oam_wdata_o = bus_rdata_i;
                oam_wr_o    = 1'b1;
            end
            if (is_reg) begin
                cpu_rdata_o = src_q;
            end else if (grant) begin
                cpu_rdata_o = bus_rdata_i;
            end else begin
                cpu_rdata_o = 8'hFF;
            end
        end
    end

    assign bus_addr_o   = bus.addr;
    assign bus_wdata_o  = bus.wdata;
    assign bus_rd_o     = bus.rd;
    assign bus_wr_o     = bus.wr;
    assign cpu_grant_o  = grant;
    assign dma_active_o = dma_active;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb_oam_dma_arbiter: directed + randomized bench for oam_dma_arbiter (default parameters).
module tb_oam_dma_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_rdata;
    logic        cpu_grant;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_rd;
    logic        bus_wr;
    logic [7:0]  bus_rdata = '0;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_wr;
    logic        dma_active;

    int n_cmp = 0;
    int n_err = 0;

`ifdef OAM_DMA_RESTART_EN
    localparam bit RS = 1'b1;
`else
    localparam bit RS = 1'b0;
`endif

    // Memory image the bench believes it wrote, and the OAM contents it expects.
    logic [7:0] shadow  [0:65535];
    logic [7:0] exp_oam [0:255];
    // Behavioural memories seen by the DUT.
    logic [7:0] mem     [0:65535];
    logic [7:0] tb_oam  [0:255];

    oam_dma_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_rd_i(cpu_rd), .cpu_wr_i(cpu_wr),
        .cpu_rdata_o(cpu_rdata), .cpu_grant_o(cpu_grant),
        .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_rd_o(bus_rd), .bus_wr_o(bus_wr),
        .bus_rdata_i(bus_rdata),
        .oam_addr_o(oam_addr), .oam_wdata_o(oam_wdata), .oam_wr_o(oam_wr),
        .dma_active_o(dma_active)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with one-cycle read latency, plus the OAM target.
    always @(posedge clk) begin
        if (bus_wr) mem[bus_addr] <= bus_wdata;
        if (bus_rd) bus_rdata <= mem[bus_addr];
        if (oam_wr) tb_oam[oam_addr] <= oam_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    // Single CPU write while no copy runs; register writes must not reach the bus.
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1; cpu_rd = 1'b0;
        #2;
        chk("idle_bus_wr", {63'd0, bus_wr}, {63'd0, (a != 16'hFF46)});
        chk("idle_active", {63'd0, dma_active}, 64'd0);
        if (a != 16'hFF46) begin
            chk("idle_bus_addr", {48'd0, bus_addr}, {48'd0, a});
            shadow[a] = d;
        end
        tick();
        cpu_idle();
    endtask

    // Model of one copy measured from the register-write edge: cycle t=1 is the delay
    // cycle, then even t are READs and odd t are WRITEs of byte (t-2)/2.
    task automatic run_dma(input logic [7:0] src, input bit directed, input int stop_t,
                           input int rs_idx, input logic [7:0] nsrc);
        int t = 1;
        int cyc = 0;
        bit done_rs = 1'b0;
        logic [7:0] cur = src;
        while (t <= stop_t && cyc < 2000) begin
            bit rd_ph, wr_ph, restart, isreg, hram, g;
            logic [7:0] ix;
            rd_ph = (t >= 2) && (t % 2 == 0);
            wr_ph = (t >= 3) && (t % 2 == 1);
            ix = 8'((t - 2) / 2);
            restart = 1'b0;
            cpu_idle();
            if (rs_idx >= 0 && wr_ph && int'(ix) == rs_idx && !done_rs) begin
                cpu_addr = 16'hFF46; cpu_wr = 1'b1; cpu_wdata = nsrc;
                restart = 1'b1; done_rs = 1'b1;
            end else if (directed && t == 50) begin
                cpu_addr = 16'hC000; cpu_rd = 1'b1;
            end else if (directed && t == 51) begin
                cpu_addr = 16'hFF90; cpu_rd = 1'b1;
            end else if (directed && (t == 60 || t == 61)) begin
                cpu_addr = 16'hFF80; cpu_wr = 1'b1; cpu_wdata = 8'h3C;
            end else if (directed && t == 71) begin
                cpu_addr = 16'hFF7F; cpu_rd = 1'b1;
            end else if (directed && t == 73) begin
                cpu_addr = 16'hFFFF; cpu_rd = 1'b1;
            end else if (directed && t == 75) begin
                cpu_addr = 16'hFFFE; cpu_rd = 1'b1;
            end else if (directed && t == 100) begin
                cpu_addr = 16'hFF46; cpu_rd = 1'b1;
            end else begin
                case ($urandom_range(0, 5))
                    1: begin cpu_rd = 1'b1; cpu_addr = 16'hC000 + 16'($urandom_range(0, 255)); end
                    2: begin cpu_rd = 1'b1; cpu_addr = 16'hFF80 + 16'($urandom_range(0, 126)); end
                    3: begin cpu_rd = 1'b1; cpu_addr = 16'hFF46; end
                    4: begin cpu_wr = 1'b1; cpu_addr = 16'hFFA0 + 16'($urandom_range(0, 94));
                             cpu_wdata = 8'($urandom); end
                    5: begin cpu_rd = 1'b1; cpu_addr = 16'h0000; end
                    default: ;
                endcase
            end
            #2;
            isreg = (cpu_addr == 16'hFF46);
            hram  = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
            g     = hram && !rd_ph;
            chk("dma_active", {63'd0, dma_active}, 64'd1);
            chk("grant", {63'd0, cpu_grant}, {63'd0, g});
            chk("bus_wr", {63'd0, bus_wr}, {63'd0, g && cpu_wr});
            if (g && cpu_wr) chk("bus_wdata", {56'd0, bus_wdata}, {56'd0, cpu_wdata});
            if (rd_ph) begin
                chk("dma_bus_rd", {63'd0, bus_rd}, 64'd1);
                chk("dma_bus_addr", {48'd0, bus_addr}, {48'd0, cur, ix});
            end else begin
                chk("cpu_bus_rd", {63'd0, bus_rd}, {63'd0, g && cpu_rd});
                if (g) chk("cpu_bus_addr", {48'd0, bus_addr}, {48'd0, cpu_addr});
            end
            chk("oam_wr", {63'd0, oam_wr}, {63'd0, wr_ph});
            if (wr_ph) begin
                chk("oam_addr", {56'd0, oam_addr}, {56'd0, ix});
                chk("oam_wdata", {56'd0, oam_wdata}, {56'd0, shadow[{cur, ix}]});
                exp_oam[ix] = shadow[{cur, ix}];
            end
            if (cpu_rd && isreg) chk("reg_rd", {56'd0, cpu_rdata}, {56'd0, cur});
            else if (cpu_rd && !g) chk("blocked_rd", {56'd0, cpu_rdata}, 64'hFF);
            if (g && cpu_wr) shadow[cpu_addr] = cpu_wdata;
            if (directed && t == 50) chk("t3_c000_grant", {63'd0, cpu_grant}, 64'd0);
            if (directed && t == 51) chk("t3_ff90_grant", {63'd0, cpu_grant}, 64'd1);
            if (directed && t == 60) chk("t4_stall_wr", {63'd0, bus_wr}, 64'd0);
            if (directed && t == 61) chk("t4_retry_wr", {63'd0, bus_wr}, 64'd1);
            if (directed && t == 100) chk("t5_reg", {56'd0, cpu_rdata}, 64'hC1);
            tick();
            cyc++;
            if (restart && RS) begin
                t = 1;
                cur = nsrc;
            end else begin
                t++;
            end
        end
        chk("dma_cycle_budget", {63'd0, (cyc < 2000)}, 64'd1);
        cpu_idle();
    endtask

    task automatic check_oam(input string tag);
        for (int i = 0; i < 160; i++) begin
            chk(tag, {48'd0, 8'(i), tb_oam[i]}, {48'd0, 8'(i), exp_oam[i]});
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            exp_oam[i] = 8'h00;
            tb_oam[i]  = 8'h00;
        end

        // Reset state.
        tick();
        #2;
        chk("rst_outputs", {cpu_rdata, cpu_grant, bus_addr, bus_wdata, bus_rd, bus_wr,
                            oam_addr, oam_wdata, oam_wr, dma_active}, 64'd0);
        tick();
        rst = 1'b0;
        cpu_addr = 16'hFF46; cpu_rd = 1'b1;
        #2;
        chk("post_rst_grant", {63'd0, cpu_grant}, 64'd1);
        chk("post_rst_active", {63'd0, dma_active}, 64'd0);
        chk("post_rst_src", {56'd0, cpu_rdata}, 64'd0);
        tick();
        cpu_idle();

        // Source pages C1 and D0 with random contents, and one HRAM byte.
        for (int i = 0; i < 160; i++) begin
            cpu_write(16'hC100 + 16'(i), 8'($urandom));
            cpu_write(16'hD000 + 16'(i), 8'($urandom));
        end
        cpu_write(16'hFF90, 8'h5A);

        // Full copy from C1 with directed arbitration checks along the way.
        cpu_write(16'hFF46, 8'hC1);
        run_dma(8'hC1, 1'b1, 321, -1, 8'h00);
        #2;
        chk("t2_done_321", {63'd0, dma_active}, 64'd0);
        check_oam("t2_oam");
        cpu_addr = 16'hFF80; cpu_rd = 1'b1;
        tick();
        cpu_idle();
        #2;
        chk("t4_ff80_data", {56'd0, cpu_rdata}, {56'd0, shadow[16'hFF80]});

        // New data in C1, then a register write of D0 at byte 40.
        for (int i = 0; i < 160; i++) cpu_write(16'hC100 + 16'(i), 8'($urandom));
        cpu_write(16'hFF46, 8'hC1);
        run_dma(8'hC1, 1'b0, 321, 40, 8'hD0);
        #2;
        chk("t6_done", {63'd0, dma_active}, 64'd0);
        check_oam("t6_oam");
        cpu_addr = 16'hFF46; cpu_rd = 1'b1;
        #1;
        chk("t6_src", {56'd0, cpu_rdata}, RS ? 64'hD0 : 64'hC1);
        tick();
        cpu_idle();

        // Reset in the middle of a WRITE cycle.
        cpu_write(16'hFF46, 8'hC1);
        run_dma(8'hC1, 1'b0, 10, -1, 8'h00);
        cpu_addr = 16'hFF90; cpu_rd = 1'b1;
        #2;
        chk("t1_in_write", {63'd0, oam_wr}, 64'd1);
        rst = 1'b1;
        #1;
        chk("t1_rst_outputs", {cpu_rdata, cpu_grant, bus_addr, bus_wdata, bus_rd, bus_wr,
                               oam_addr, oam_wdata, oam_wr, dma_active}, 64'd0);
        tick();
        rst = 1'b0;
        cpu_addr = 16'hFF46; cpu_rd = 1'b1;
        #2;
        chk("t1_active_after", {63'd0, dma_active}, 64'd0);
        chk("t1_src_cleared", {56'd0, cpu_rdata}, 64'd0);
        tick();
        cpu_idle();
        check_oam("t1_oam_kept");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
